// File: rtl/check_queue.sv
// check_queue: registers PNUMS lanes of decoded instruction fields between decode2
// and scheduler1. Each bundle is decoded (immediate, CSR, legal-format flag) as it is
// pushed, then held in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Optional feature macro: CHECK_QUEUE_ILLEGAL_CNT_EN adds the ILLEGAL_CNT output, a
// saturating count of illegal lanes across all pushed bundles.
module check_queue #(
    parameter int COP_NUMS = 1,
    parameter int PNUMS    = COP_NUMS + 1,
    parameter int DEPTH    = 2,
    parameter int SIGN_EXT = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 FLUSH,
    input  logic                 MMU_WAIT,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [32*PNUMS-1:0]  PC,
    input  logic [17*PNUMS-1:0]  OPCODE,
    input  logic [5*PNUMS-1:0]   RD,
    input  logic [5*PNUMS-1:0]   RS1,
    input  logic [5*PNUMS-1:0]   RS2,
    input  logic [32*PNUMS-1:0]  RINST,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
    output logic [31:0]          ILLEGAL_CNT,
`endif
    output logic [PNUMS-1:0]     CHECK_ACCEPT,
    output logic [32*PNUMS-1:0]  CHECK_PC,
    output logic [17*PNUMS-1:0]  CHECK_OPCODE,
    output logic [5*PNUMS-1:0]   CHECK_RD,
    output logic [5*PNUMS-1:0]   CHECK_RS1,
    output logic [5*PNUMS-1:0]   CHECK_RS2,
    output logic [12*PNUMS-1:0]  CHECK_CSR,
    output logic [32*PNUMS-1:0]  CHECK_IMM
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // addi x0,x0,0 in {opcode7,funct3,funct7} layout
    localparam logic [16:0] NOP_OPCODE = {7'b0010011, 3'b000, 7'b0000000};

    typedef struct packed {
        logic [32*PNUMS-1:0] pc;
        logic [17*PNUMS-1:0] opcode;
        logic [5*PNUMS-1:0]  rd;
        logic [5*PNUMS-1:0]  rs1;
        logic [5*PNUMS-1:0]  rs2;
        logic [12*PNUMS-1:0] csr;
        logic [32*PNUMS-1:0] imm;
        logic [PNUMS-1:0]    accept;
    } bundle_t;

    // Returns {accept, imm}; unknown opcodes give accept=0 and imm=0.
    function automatic logic [32:0] decode_imm(input logic [31:0] inst);
        logic        sx;
        logic [32:0] res;
        sx  = (SIGN_EXT != 0) && inst[31];
        res = {1'b1, 32'h0};
        case (inst[6:0])
            7'b0110011: res[31:0] = 32'h0;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011:
                res[31:0] = {{20{sx}}, inst[31:20]};
            7'b0100011: res[31:0] = {{20{sx}}, inst[31:25], inst[11:7]};
            7'b1100011: res[31:0] = {{19{sx}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111: res[31:0] = {inst[31:12], 12'h000};
            7'b1101111: res[31:0] = {{11{sx}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: res = 33'h0;
        endcase
        return res;
    endfunction

    bundle_t        mem [DEPTH];
    bundle_t        in_bundle_p0;
    bundle_t        head_p1;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign IN_READY  = !full && !MMU_WAIT;
    assign OUT_VALID = !empty;
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    // Stage p0: assemble the incoming bundle and decode immediates/CSR per lane
    always_comb begin
        logic [32:0] dec;
        in_bundle_p0        = '0;
        in_bundle_p0.pc     = PC;
        in_bundle_p0.opcode = OPCODE;
        in_bundle_p0.rd     = RD;
        in_bundle_p0.rs1    = RS1;
        in_bundle_p0.rs2    = RS2;
        for (int l = 0; l < PNUMS; l++) begin
            dec = decode_imm(RINST[32*l +: 32]);
            in_bundle_p0.imm[32*l +: 32] = dec[31:0];
            in_bundle_p0.accept[l]       = dec[32];
            in_bundle_p0.csr[12*l +: 12] = RINST[32*l+20 +: 12];
        end
    end

    // Queue control: pointers and occupancy; flush and reset drop everything, including this cycle's push/pop
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage p1: bundle storage, written on push (data path carries no reset)
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_bundle_p0;
    end

    // Head bundle, or the NOP bundle while the queue is empty
    always_comb begin
        head_p1        = '0;
        head_p1.accept = '1;
        for (int l = 0; l < PNUMS; l++) head_p1.opcode[17*l +: 17] = NOP_OPCODE;
        if (!empty) head_p1 = mem[rd_ptr];
    end

    assign CHECK_PC     = head_p1.pc;
    assign CHECK_OPCODE = head_p1.opcode;
    assign CHECK_RD     = head_p1.rd;
    assign CHECK_RS1    = head_p1.rs1;
    assign CHECK_RS2    = head_p1.rs2;
    assign CHECK_CSR    = head_p1.csr;
    assign CHECK_IMM    = head_p1.imm;
    assign CHECK_ACCEPT = head_p1.accept;

`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hffff_ffff : sum[31:0];
    endfunction

    logic [31:0] n_illegal;
    logic [31:0] illegal_cnt;

    // Number of illegal lanes in the incoming bundle
    always_comb begin
        n_illegal = 32'h0;
        for (int l = 0; l < PNUMS; l++) n_illegal = n_illegal + {31'h0, ~in_bundle_p0.accept[l]};
    end

    // Saturating illegal-lane counter; only reset clears it, flushed pushes do not count
    always_ff @(posedge CLK) begin
        if (RST)                 illegal_cnt <= 32'h0;
        else if (push && !FLUSH) illegal_cnt <= sat_add32(illegal_cnt, n_illegal);
    end

    assign ILLEGAL_CNT = illegal_cnt;
`endif

endmodule

// File: tb/tb_check_queue.sv
// Directed bench for check_queue: two instances (zero- and sign-extending immediates)
// driven by the same stimulus, checked with immediate assertions at each step.
module tb_check_queue;

    localparam int P = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            RST, FLUSH, MMU_WAIT, IN_VALID, OUT_READY;
    logic [32*P-1:0] PC, RINST;
    logic [17*P-1:0] OPCODE;
    logic [5*P-1:0]  RD, RS1, RS2;

    logic            IN_READY, OUT_VALID;
    logic [P-1:0]    CHECK_ACCEPT;
    logic [32*P-1:0] CHECK_PC, CHECK_IMM;
    logic [17*P-1:0] CHECK_OPCODE;
    logic [5*P-1:0]  CHECK_RD, CHECK_RS1, CHECK_RS2;
    logic [12*P-1:0] CHECK_CSR;

    logic            s_in_ready, s_out_valid;
    logic [P-1:0]    s_accept;
    logic [32*P-1:0] s_pc, s_imm;
    logic [17*P-1:0] s_opcode;
    logic [5*P-1:0]  s_rd, s_rs1, s_rs2;
    logic [12*P-1:0] s_csr;
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
    logic [31:0]     ILLEGAL_CNT, s_illegal_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    check_queue #(.COP_NUMS(1), .PNUMS(P), .DEPTH(2), .SIGN_EXT(0)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MMU_WAIT(MMU_WAIT),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .PC(PC), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2), .RINST(RINST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
        .ILLEGAL_CNT(ILLEGAL_CNT),
`endif
        .CHECK_ACCEPT(CHECK_ACCEPT), .CHECK_PC(CHECK_PC), .CHECK_OPCODE(CHECK_OPCODE),
        .CHECK_RD(CHECK_RD), .CHECK_RS1(CHECK_RS1), .CHECK_RS2(CHECK_RS2),
        .CHECK_CSR(CHECK_CSR), .CHECK_IMM(CHECK_IMM)
    );

    check_queue #(.COP_NUMS(1), .PNUMS(P), .DEPTH(2), .SIGN_EXT(1)) dut_sx (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MMU_WAIT(MMU_WAIT),
        .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
        .PC(PC), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2), .RINST(RINST),
        .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY),
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
        .ILLEGAL_CNT(s_illegal_cnt),
`endif
        .CHECK_ACCEPT(s_accept), .CHECK_PC(s_pc), .CHECK_OPCODE(s_opcode),
        .CHECK_RD(s_rd), .CHECK_RS1(s_rs1), .CHECK_RS2(s_rs2),
        .CHECK_CSR(s_csr), .CHECK_IMM(s_imm)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [16:0] opf(input logic [31:0] i);
        return {i[6:0], i[14:12], i[31:25]};
    endfunction

    task automatic set_bundle(input logic [31:0] pc0, input logic [31:0] i0,
                              input logic [31:0] pc1, input logic [31:0] i1);
        PC     = {pc1, pc0};
        RINST  = {i1, i0};
        OPCODE = {opf(i1), opf(i0)};
        RD     = {i1[11:7], i0[11:7]};
        RS1    = {i1[19:15], i0[19:15]};
        RS2    = {i1[24:20], i0[24:20]};
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; MMU_WAIT = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        set_bundle(32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        RST = 1'b0;

        // Empty after reset: NOP bundle shown
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_opcode0", CHECK_OPCODE[16:0], 17'h04C00);
        chk("rst_accept", CHECK_ACCEPT, 2'b11);
        chk("rst_imm", CHECK_IMM, 0);
        chk("rst_pc", CHECK_PC, 0);
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
        chk("rst_illegal_cnt", ILLEGAL_CNT, 0);
`endif

        // addi x1,x0,-1 on lane 0, add x3,x1,x2 on lane 1
        set_bundle(32'h1000, 32'hfff00093, 32'h1004, 32'h002081b3);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("addi_out_valid", OUT_VALID, 1);
        chk("addi_imm_zx", CHECK_IMM[31:0], 32'h0000_0fff);
        chk("addi_accept", CHECK_ACCEPT, 2'b11);
        chk("addi_pc0", CHECK_PC[31:0], 32'h1000);
        chk("addi_csr0", CHECK_CSR[11:0], 12'hfff);
        chk("addi_opcode0", CHECK_OPCODE[16:0], 17'h04C7F);
        chk("add_imm1", CHECK_IMM[63:32], 0);
        chk("sx_out_valid", s_out_valid, 1);
        chk("sx_in_ready", s_in_ready, 1);
        chk("sx_imm", s_imm, {32'h0, 32'hffff_ffff});
        chk("sx_accept", s_accept, 2'b11);
        chk("sx_pc", s_pc, {32'h1004, 32'h1000});
        chk("sx_opcode", s_opcode, {17'h0CC00, 17'h04C7F});
        chk("sx_rd", s_rd, {5'd3, 5'd1});
        chk("sx_rs1", s_rs1, {5'd1, 5'd0});
        chk("sx_rs2", s_rs2, {5'd2, 5'd31});
        chk("sx_csr", s_csr, {12'h002, 12'hfff});
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("drain_out_valid", OUT_VALID, 0);
        chk("drain_imm", CHECK_IMM, 0);
        chk("drain_opcode0", CHECK_OPCODE[16:0], 17'h04C00);

        // Fill to DEPTH with OUT_READY low, third bundle is held
        set_bundle(32'h100, 32'hFE512E23, 32'h104, 32'hFE2098E3);   // sw x5,-4(x2) | bne x1,x2,-16
        IN_VALID = 1'b1;
        tick();
        set_bundle(32'h200, 32'h123453B7, 32'h204, 32'h002081b3);   // lui x7,0x12345 | add
        tick();
        chk("full_in_ready", IN_READY, 0);
        chk("full_out_valid", OUT_VALID, 1);
        chk("full_head_pc", CHECK_PC[31:0], 32'h100);
        chk("s_imm_zx", CHECK_IMM[31:0], 32'h0000_0ffc);
        chk("b_imm_zx", CHECK_IMM[63:32], 32'h0000_1ff0);
        chk("sb_imm_sx", s_imm, {32'hffff_fff0, 32'hffff_fffc});
        set_bundle(32'h300, 32'h0080006F, 32'h304, 32'hfff00093);   // jal x0,8 | addi
        tick();
        chk("held_in_ready", IN_READY, 0);
        chk("held_head_pc", CHECK_PC[31:0], 32'h100);
        OUT_READY = 1'b1;
        tick();
        chk("pop1_head_pc", CHECK_PC[31:0], 32'h200);
        chk("pop1_in_ready", IN_READY, 1);
        chk("u_imm", CHECK_IMM[31:0], 32'h1234_5000);
        tick();
        chk("pop2_head_pc", CHECK_PC[31:0], 32'h300);
        chk("j_imm", CHECK_IMM[31:0], 32'h0000_0008);
        chk("c_lane1_imm", CHECK_IMM[63:32], 32'h0000_0fff);
        IN_VALID = 1'b0;
        tick();
        OUT_READY = 1'b0;
        chk("pop3_out_valid", OUT_VALID, 0);

        // Streaming at count 1: push and pop together every cycle
        set_bundle(32'h0, 32'h00000093, 32'h4, 32'h002081b3);
        IN_VALID = 1'b1;
        tick();
        OUT_READY = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            logic [31:0] ai;
            ai = {i[11:0], 20'h00093};
            set_bundle(i * 16, ai, i * 16 + 4, 32'h002081b3);
            tick();
            chk("stream_out_valid", OUT_VALID, 1);
            chk("stream_pc", CHECK_PC[31:0], i * 16);
            chk("stream_imm", CHECK_IMM[31:0], i);
        end
        IN_VALID = 1'b0;
        tick();
        OUT_READY = 1'b0;
        chk("stream_end_valid", OUT_VALID, 0);

        // Illegal opcode on lane 1
        set_bundle(32'h500, 32'h00500113, 32'h504, 32'h0000007f);   // addi x2,x0,5 | illegal
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("ill_out_valid", OUT_VALID, 1);
        chk("ill_accept", CHECK_ACCEPT, 2'b01);
        chk("ill_imm1", CHECK_IMM[63:32], 0);
        chk("ill_imm0", CHECK_IMM[31:0], 5);
        chk("ill_pc1", CHECK_PC[63:32], 32'h504);
        chk("ill_opcode1", CHECK_OPCODE[33:17], 17'h1FC00);
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
        chk("ill_cnt", ILLEGAL_CNT, 1);
        chk("ill_cnt_sx", s_illegal_cnt, 1);
`endif

        // MMU_WAIT blocks enqueue but the head still drains
        MMU_WAIT = 1'b1;
        set_bundle(32'h600, 32'h00500113, 32'h604, 32'h002081b3);
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        #1;
        chk("mmu_in_ready", IN_READY, 0);
        tick();
        chk("mmu_drained", OUT_VALID, 0);
        MMU_WAIT = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;

        // FLUSH with a full queue, push and pop requested in the same cycle
        set_bundle(32'h700, 32'h00500113, 32'h704, 32'h002081b3);
        IN_VALID = 1'b1;
        tick();
        set_bundle(32'h800, 32'h00500113, 32'h804, 32'h002081b3);
        tick();
        chk("pre_flush_full", IN_READY, 0);
        FLUSH = 1'b1; OUT_READY = 1'b1;
        set_bundle(32'h900, 32'h00500113, 32'h904, 32'h0000007f);
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        chk("flush_out_valid", OUT_VALID, 0);
        chk("flush_in_ready", IN_READY, 1);
        chk("flush_pc", CHECK_PC, 0);
        chk("flush_accept", CHECK_ACCEPT, 2'b11);
        chk("flush_opcode1", CHECK_OPCODE[33:17], 17'h04C00);

        // FLUSH at count 1 where the push would otherwise be accepted
        set_bundle(32'hA00, 32'h00500113, 32'hA04, 32'h002081b3);
        IN_VALID = 1'b1;
        tick();
        FLUSH = 1'b1;
        set_bundle(32'h900, 32'h00500113, 32'h904, 32'h0000007f);
        tick();
        FLUSH = 1'b0;
        chk("flush2_out_valid", OUT_VALID, 0);
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
        chk("flush_cnt_kept", ILLEGAL_CNT, 1);
`endif
        set_bundle(32'hB00, 32'h00500113, 32'hB04, 32'h002081b3);
        tick();
        IN_VALID = 1'b0;
        chk("post_flush_head", CHECK_PC[31:0], 32'hB00);
        chk("post_flush_valid", OUT_VALID, 1);

        // Reset mid-operation
        RST = 1'b1; IN_VALID = 1'b1;
        set_bundle(32'hC00, 32'h00500113, 32'hC04, 32'h0000007f);
        tick();
        RST = 1'b0; IN_VALID = 1'b0;
        chk("midrst_out_valid", OUT_VALID, 0);
        chk("midrst_in_ready", IN_READY, 1);
        chk("midrst_imm", CHECK_IMM, 0);
`ifdef CHECK_QUEUE_ILLEGAL_CNT_EN
        chk("midrst_cnt", ILLEGAL_CNT, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
